// File: rtl/intra_4x4_mode_buf_pkg.sv
// Shared types, constants and 4x4 block-index helpers for the intra 4x4 mode buffer.
`ifndef PIC_W_MB_LEN
`define PIC_W_MB_LEN 4
`endif
`ifndef PIC_H_MB_LEN
`define PIC_H_MB_LEN 4
`endif

package intra_4x4_mode_buf_pkg;

  localparam int unsigned MODE_W = 4;
  localparam int unsigned REM_W  = 3;

  typedef logic [MODE_W-1:0] mode_t;
  typedef logic [REM_W-1:0]  rem_t;
  typedef logic [1:0]        coord_t;

  localparam mode_t DC_MODE = 4'd2;

  function automatic coord_t blk_bx(input logic [3:0] num);
    return {num[2], num[0]};
  endfunction

  function automatic coord_t blk_by(input logic [3:0] num);
    return {num[3], num[1]};
  endfunction

  function automatic logic [3:0] blk_idx(input coord_t bx, input coord_t by);
    return {by[1], bx[1], by[0], bx[0]};
  endfunction

  // Most-probable mode: min of left/top neighbour, DC if either is unavailable.
  function automatic mode_t pred_mode(input logic [3:0] num, input mode_t [15:0] cur,
                                      input mode_t [3:0] left, input mode_t [3:0] top,
                                      input logic left_mb_av, input logic top_mb_av,
                                      input mode_t dc);
    coord_t bx;
    coord_t by;
    logic   a_av;
    logic   b_av;
    mode_t  a;
    mode_t  b;
    bx   = blk_bx(num);
    by   = blk_by(num);
    a_av = (bx != 2'd0) || left_mb_av;
    b_av = (by != 2'd0) || top_mb_av;
    a    = (bx != 2'd0) ? cur[blk_idx(bx - 2'd1, by)] : left[by];
    b    = (by != 2'd0) ? cur[blk_idx(bx, by - 2'd1)] : top[bx];
    if (a_av && b_av) return (a < b) ? a : b;
    return dc;
  endfunction

endpackage

// File: rtl/intra_4x4_mode_line_ram.sv
// Single-port synchronous line RAM holding the bottom-row modes of each MB column.
module intra_4x4_mode_line_ram #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4,
  parameter int unsigned DW    = 16
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/intra_4x4_mode_buf.sv
// Intra 4x4 mode buffer: predicted-mode responder, neighbour storage and entropy read bank.
// Optional same-cycle write-to-query forwarding under `INTRA4X4_MODE_FWD_EN.
module intra_4x4_mode_buf
  import intra_4x4_mode_buf_pkg::*;
#(
  parameter int unsigned MB_W_MAX = 1 << `PIC_W_MB_LEN,
  parameter mode_t       DC_MODE  = intra_4x4_mode_buf_pkg::DC_MODE
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [`PIC_W_MB_LEN-1:0] mb_x,
  input  logic [`PIC_H_MB_LEN-1:0] mb_y,
  input  logic                     mb_start_i,
  output logic                     ready_o,
  input  logic                     mb_done_i,
  input  logic                     mb_i4x4_i,
  input  logic [3:0]               i4x4_num_i,
  output logic [3:0]               i4x4_pred_mode_o,
  input  logic                     i4x4_min_val_i,
  input  logic [3:0]               i4x4_min_mode_i,
  input  logic [3:0]               i4x4_min_num_i,
  input  logic                     ec_rd_en_i,
  input  logic [3:0]               ec_rd_num_i,
  output logic                     ec_flag_o,
  output logic [2:0]               ec_rem_o,
  output logic                     ec_rdy_o
);

  localparam int unsigned AW = `PIC_W_MB_LEN;

  typedef enum logic [1:0] {IDLE, RD, ACTIVE, COMMIT} state_t;

  state_t                   state, state_nxt;
  logic [AW-1:0]            mb_x_q;
  logic [`PIC_H_MB_LEN-1:0] mb_y_q;
  mode_t [15:0]             cur, cur_view;
  logic  [15:0]             flag, ec_flag_bank;
  rem_t  [15:0]             rem, ec_rem_bank;
  mode_t [3:0]              left, top, row3, col3;
  logic                     i4x4_q;
  logic                     wr_en, wr_flag;
  mode_t                    wr_pred;
  rem_t                     wr_rem;
  logic                     ram_we;
  logic [AW-1:0]            ram_addr;
  logic [15:0]              ram_wdata, ram_rdata;

  intra_4x4_mode_line_ram #(
    .DEPTH (MB_W_MAX),
    .AW    (AW),
    .DW    (16)
  ) u_line_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (mb_start_i) state_nxt = RD;
      RD:      state_nxt = ACTIVE;
      ACTIVE:  if (mb_done_i) state_nxt = COMMIT;
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign ready_o = (state == IDLE);
  assign wr_en   = i4x4_min_val_i && (state == ACTIVE);

  always_comb begin
    cur_view = cur;
`ifdef INTRA4X4_MODE_FWD_EN
    if (wr_en) cur_view[i4x4_min_num_i] = i4x4_min_mode_i;
`endif
  end

  always_comb begin
    i4x4_pred_mode_o = DC_MODE;
    if (state == ACTIVE)
      i4x4_pred_mode_o = pred_mode(i4x4_num_i, cur_view, left, top,
                                   mb_x_q != '0, mb_y_q != '0, DC_MODE);
  end

  always_comb begin
    wr_pred = pred_mode(i4x4_min_num_i, cur, left, top, mb_x_q != '0, mb_y_q != '0, DC_MODE);
    wr_flag = (i4x4_min_mode_i == wr_pred);
    wr_rem  = (i4x4_min_mode_i < wr_pred) ? i4x4_min_mode_i[2:0] : rem_t'(i4x4_min_mode_i - 4'd1);
  end

  // Non-I4x4 MBs present DC to both the next MB and the row below.
  always_comb begin
    for (int unsigned i = 0; i < 4; i++) begin
      row3[i] = i4x4_q ? cur[blk_idx(coord_t'(i), 2'd3)] : DC_MODE;
      col3[i] = i4x4_q ? cur[blk_idx(2'd3, coord_t'(i))] : DC_MODE;
    end
  end

  assign ram_we    = (state == COMMIT);
  assign ram_addr  = (state == COMMIT) ? mb_x_q : mb_x;
  assign ram_wdata = row3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      mb_x_q       <= '0;
      mb_y_q       <= '0;
      cur          <= '0;
      flag         <= '0;
      rem          <= '0;
      left         <= '0;
      top          <= '0;
      i4x4_q       <= 1'b0;
      ec_flag_bank <= '0;
      ec_rem_bank  <= '0;
      ec_rdy_o     <= 1'b0;
      ec_flag_o    <= 1'b0;
      ec_rem_o     <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && mb_start_i) begin
        mb_x_q <= mb_x;
        mb_y_q <= mb_y;
      end
      if (state == RD) top <= ram_rdata;
      if (wr_en) begin
        cur[i4x4_min_num_i]  <= i4x4_min_mode_i;
        flag[i4x4_min_num_i] <= wr_flag;
        rem[i4x4_min_num_i]  <= wr_rem;
      end
      if (state == ACTIVE && mb_done_i) i4x4_q <= mb_i4x4_i;
      if (state == COMMIT) begin
        left         <= col3;
        ec_flag_bank <= flag;
        ec_rem_bank  <= rem;
        ec_rdy_o     <= 1'b1;
      end
      if (ec_rd_en_i) begin
        ec_flag_o <= ec_flag_bank[ec_rd_num_i];
        ec_rem_o  <= ec_rem_bank[ec_rd_num_i];
      end
    end
  end

endmodule
